// File: rtl/calu_seq.sv
// calu_seq: multi-cycle complex ALU behind valid/ready handshakes.
// Operands pack {real, imag}. ADD/SUB/CONJ/SWAP finish at the acceptance edge.
// MUL/DIV pass through a product stage. DIV then runs two restoring dividers,
// one per part, for 2W cycles.
module calu_seq #(
    parameter int unsigned W   = 16,
    parameter int unsigned SAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [2*W-1:0] z1,
    input  logic [2*W-1:0] z2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] zout,
    output logic [5:0]     flags_r,
    output logic [5:0]     flags_i,
    output logic           illegal
);

    localparam int unsigned P     = 2 * W;
    localparam int unsigned CW    = $clog2(P);
    localparam bit          SatEn = (SAT != 0);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpDiv  = 3'b011;
    localparam logic [2:0] OpConj = 3'b100;
    localparam logic [2:0] OpSwap = 3'b101;

    localparam logic [W-1:0] SMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMin = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StProd, StDiv, StDone} state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [P-1:0]  qr_q, qr_d, qi_q, qi_d;   // numerator in, quotient out
    logic [P-1:0]  rr_q, rr_d, ri_q, ri_d;   // partial remainders
    logic [P-1:0]  den_q, den_d;
    logic          neg_r_q, neg_r_d, neg_i_q, neg_i_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [P-1:0]  zout_q, zout_d;
    logic [5:0]    flr_q, flr_d, fli_q, fli_d;
    logic          ill_q, ill_d;

    // Flag vector {ZE, DVF, V, C, N, Z} for one W-bit result part.
    function automatic logic [5:0] mk_flags(input logic [W-1:0] r, input logic ze,
                                            input logic dvf, input logic v, input logic c);
        return {ze, dvf, v, c, r[W-1], (r == '0)};
    endfunction

    // x + (y or ~y) + sub, returns {flags, result}.
    function automatic logic [W+5:0] addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sub);
        logic [W-1:0] yx;
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v;
        yx = sub ? ~y : y;
        s  = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, sub};
        v  = (x[W-1] == yx[W-1]) && (s[W-1] != x[W-1]);
        r  = s[W-1:0];
        if (v && SatEn) r = x[W-1] ? SMin : SMax;
        return {mk_flags(r, 1'b0, 1'b0, v, s[W]), r};
    endfunction

    // Narrow a wide signed value to W bits; overflow reported as V or DVF.
    function automatic logic [W+5:0] fit(input logic [P:0] x, input logic sat_en,
                                         input logic as_dvf);
        logic         ovf;
        logic [W-1:0] r;
        ovf = !((&x[P:W-1]) || !(|x[P:W-1]));
        r   = x[W-1:0];
        if (ovf && sat_en) r = x[P] ? SMin : SMax;
        return {mk_flags(r, 1'b0, as_dvf & ovf, ~as_dvf & ovf, 1'b0), r};
    endfunction

    // One restoring-division iteration, returns {remainder, quotient/numerator}.
    // The remainder stays below den <= 2^(P-1), so the shifted value fits P bits.
    function automatic logic [2*P-1:0] div_step(input logic [P-1:0] rem,
                                                input logic [P-1:0] quo,
                                                input logic [P-1:0] den);
        logic [P:0] sh;
        logic [P:0] tr;
        sh = {rem, quo[P-1]};
        tr = sh - {1'b0, den};
        if (tr[P]) return {sh[P-1:0], quo[P-2:0], 1'b0};
        return {tr[P-1:0], quo[P-2:0], 1'b1};
    endfunction

    logic signed [P-1:0] ac, bd, ad, bc, cc, dd;
    logic        [P:0]   mul_re, mul_im, num_r, num_i;
    logic        [P-1:0] den, mag_r, mag_i;
    logic [2*P-1:0]      st_r, st_i;
    logic        [P:0]   sq_r, sq_i;

    // Product stage, divider iteration and final quotient sign.
    always_comb begin
        ac     = $signed(a_q) * $signed(c_q);
        bd     = $signed(b_q) * $signed(d_q);
        ad     = $signed(a_q) * $signed(d_q);
        bc     = $signed(b_q) * $signed(c_q);
        cc     = $signed(c_q) * $signed(c_q);
        dd     = $signed(d_q) * $signed(d_q);
        mul_re = {ac[P-1], ac} - {bd[P-1], bd};
        mul_im = {ad[P-1], ad} + {bc[P-1], bc};
        num_r  = {ac[P-1], ac} + {bd[P-1], bd};
        num_i  = {bc[P-1], bc} - {ad[P-1], ad};
        den    = cc + dd;
        mag_r  = num_r[P] ? P'(-num_r) : P'(num_r);
        mag_i  = num_i[P] ? P'(-num_i) : P'(num_i);
        st_r   = div_step(rr_q, qr_q, den_q);
        st_i   = div_step(ri_q, qi_q, den_q);
        sq_r   = neg_r_q ? -{1'b0, st_r[P-1:0]} : {1'b0, st_r[P-1:0]};
        sq_i   = neg_i_q ? -{1'b0, st_i[P-1:0]} : {1'b0, st_i[P-1:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = (op == OpMul || op == OpDiv) ? StProd : StDone;
            StProd: state_d = (op_q == OpDiv && den != '0) ? StDiv : StDone;
            StDiv:  if (cnt_q == CW'(P - 1)) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    logic [W+5:0] re_res, im_res;

    // Datapath next-state: operand capture, result formation, divider stepping.
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        qr_d    = qr_q;
        qi_d    = qi_q;
        rr_d    = rr_q;
        ri_d    = ri_q;
        den_d   = den_q;
        neg_r_d = neg_r_q;
        neg_i_d = neg_i_q;
        cnt_d   = cnt_q;
        zout_d  = zout_q;
        flr_d   = flr_q;
        fli_d   = fli_q;
        ill_d   = ill_q;
        re_res  = '0;
        im_res  = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = op;
                    a_d   = z1[P-1:W];
                    b_d   = z1[W-1:0];
                    c_d   = z2[P-1:W];
                    d_d   = z2[W-1:0];
                    cnt_d = '0;
                    case (op)
                        OpAdd, OpSub: begin
                            re_res = addsub(z1[P-1:W], z2[P-1:W], op[0]);
                            im_res = addsub(z1[W-1:0], z2[W-1:0], op[0]);
                        end
                        OpConj: begin
                            re_res = {mk_flags(z1[P-1:W], 1'b0, 1'b0, 1'b0, 1'b0), z1[P-1:W]};
                            im_res = addsub('0, z1[W-1:0], 1'b1);
                            im_res[W+2] = 1'b0;  // negation carries no meaningful C
                        end
                        OpSwap: begin
                            re_res = {mk_flags(z1[W-1:0], 1'b0, 1'b0, 1'b0, 1'b0), z1[W-1:0]};
                            im_res = {mk_flags(z1[P-1:W], 1'b0, 1'b0, 1'b0, 1'b0), z1[P-1:W]};
                        end
                        default: ;
                    endcase
                    if (op != OpMul && op != OpDiv) begin
                        zout_d = {re_res[W-1:0], im_res[W-1:0]};
                        flr_d  = re_res[W+5:W];
                        fli_d  = im_res[W+5:W];
                        ill_d  = (op[2:1] == 2'b11);
                    end
                end
            end
            StProd: begin
                if (op_q == OpMul) begin
                    re_res = fit(mul_re, SatEn, 1'b0);
                    im_res = fit(mul_im, SatEn, 1'b0);
                    zout_d = {re_res[W-1:0], im_res[W-1:0]};
                    flr_d  = re_res[W+5:W];
                    fli_d  = im_res[W+5:W];
                    ill_d  = 1'b0;
                end else if (den == '0) begin
                    zout_d = '0;
                    flr_d  = 6'b100001;
                    fli_d  = 6'b100001;
                    ill_d  = 1'b0;
                end else begin
                    qr_d    = mag_r;
                    qi_d    = mag_i;
                    rr_d    = '0;
                    ri_d    = '0;
                    den_d   = den;
                    neg_r_d = num_r[P];
                    neg_i_d = num_i[P];
                    cnt_d   = '0;
                end
            end
            StDiv: begin
                rr_d  = st_r[2*P-1:P];
                qr_d  = st_r[P-1:0];
                ri_d  = st_i[2*P-1:P];
                qi_d  = st_i[P-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(P - 1)) begin
                    re_res = fit(sq_r, 1'b0, 1'b1);
                    im_res = fit(sq_i, 1'b0, 1'b1);
                    zout_d = {re_res[W-1:0], im_res[W-1:0]};
                    flr_d  = re_res[W+5:W];
                    fli_d  = im_res[W+5:W];
                    ill_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            qr_q    <= '0;
            qi_q    <= '0;
            rr_q    <= '0;
            ri_q    <= '0;
            den_q   <= '0;
            neg_r_q <= 1'b0;
            neg_i_q <= 1'b0;
            cnt_q   <= '0;
            zout_q  <= '0;
            flr_q   <= '0;
            fli_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            qr_q    <= qr_d;
            qi_q    <= qi_d;
            rr_q    <= rr_d;
            ri_q    <= ri_d;
            den_q   <= den_d;
            neg_r_q <= neg_r_d;
            neg_i_q <= neg_i_d;
            cnt_q   <= cnt_d;
            zout_q  <= zout_d;
            flr_q   <= flr_d;
            fli_q   <= fli_d;
            ill_q   <= ill_d;
        end
    end

    assign zout    = zout_q;
    assign flags_r = flr_q;
    assign flags_i = fli_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_calu_seq.sv
// tb_calu_seq: directed checks of calu_seq at W=16, one wrapping and one
// saturating instance driven by the same stimulus.
module tb_calu_seq;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpDiv  = 3'b011;
    localparam logic [2:0] OpConj = 3'b100;
    localparam logic [2:0] OpSwap = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] z1 = '0;
    logic [31:0] z2 = '0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] zout;
    logic [5:0]  flags_r, flags_i;
    logic        in_ready_s, out_valid_s, illegal_s;
    logic [31:0] zout_s;
    logic [5:0]  flags_r_s, flags_i_s;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    calu_seq #(.W(16), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .z1(z1), .z2(z2), .out_valid(out_valid), .out_ready(out_ready), .zout(zout),
        .flags_r(flags_r), .flags_i(flags_i), .illegal(illegal)
    );

    calu_seq #(.W(16), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
        .z1(z1), .z2(z2), .out_valid(out_valid_s), .out_ready(out_ready), .zout(zout_s),
        .flags_r(flags_r_s), .flags_i(flags_i_s), .illegal(illegal_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op and wait (bounded) for out_valid; lat counts edges from acceptance.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x1, input logic [31:0] x2,
                          output int l);
        @(negedge clk);
        check("accept_rdy", in_ready, 1);
        op       = o;
        z1       = x1;
        z2       = x2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 1;
        @(negedge clk);
        while (!out_valid && l < 200) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic exp_res(input string tag, input int l, input int l_exp,
                           input logic [31:0] ze, input logic [5:0] fr, input logic [5:0] fi,
                           input logic il);
        check({tag, "_lat"}, l, l_exp);
        check({tag, "_z"}, zout, ze);
        check({tag, "_fr"}, flags_r, fr);
        check({tag, "_fi"}, flags_i, fi);
        check({tag, "_ill"}, illegal, il);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready, 1);
        check("rst_ov", out_valid, 0);
        check("rst_z", zout, 0);
        check("rst_f", {flags_r, flags_i}, 0);
        check("rst_ill", illegal, 0);
        check("rst_rdy_s", in_ready_s, 1);
        rst_n = 1'b1;

        run_op(OpAdd, 32'h0003_0004, 32'h0001_0002, lat);
        exp_res("add", lat, 1, 32'h0004_0006, 6'b000000, 6'b000000, 1'b0);
        ack();

        run_op(OpMul, 32'h0003_0004, 32'h0001_0002, lat);
        exp_res("mul", lat, 2, 32'hFFFB_000A, 6'b000010, 6'b000000, 1'b0);
        ack();

        run_op(OpDiv, 32'h0003_0004, 32'h0001_0002, lat);
        exp_res("div", lat, 34, 32'h0002_0000, 6'b000000, 6'b000001, 1'b0);
        ack();

        run_op(OpDiv, 32'h0003_0004, 32'h0000_0000, lat);
        exp_res("div0", lat, 2, 32'h0000_0000, 6'b100001, 6'b100001, 1'b0);
        ack();

        // 5-3 no borrow (C=1); 3-5 borrows (C=0) and goes negative.
        run_op(OpSub, 32'h0005_0003, 32'h0003_0005, lat);
        exp_res("sub", lat, 1, 32'h0002_FFFE, 6'b000100, 6'b000010, 1'b0);
        check("sub_z_s", zout_s, 32'h0002_FFFE);
        ack();

        run_op(OpSwap, 32'h1234_0000, 32'h5555_5555, lat);
        exp_res("swap", lat, 1, 32'h0000_1234, 6'b000001, 6'b000000, 1'b0);
        ack();

        run_op(OpConj, 32'h0001_8000, 32'h0000_0000, lat);
        exp_res("conj", lat, 1, 32'h0001_8000, 6'b000000, 6'b001010, 1'b0);
        check("conj_z_s", zout_s, 32'h0001_7FFF);
        check("conj_fi_s", flags_i_s, 6'b001000);
        ack();

        run_op(OpAdd, 32'h7FFF_0000, 32'h0001_0000, lat);
        exp_res("addovf", lat, 1, 32'h8000_0000, 6'b001010, 6'b000001, 1'b0);
        check("addovf_z_s", zout_s, 32'h7FFF_0000);
        check("addovf_fr_s", flags_r_s, 6'b001000);
        ack();

        // -7/2 truncates toward zero to -3.
        run_op(OpDiv, 32'hFFF9_0000, 32'h0002_0000, lat);
        exp_res("divneg", lat, 34, 32'hFFFD_0000, 6'b000010, 6'b000001, 1'b0);
        ack();

        // (-32768)/(i) = 32768i, outside the W-bit range.
        run_op(OpDiv, 32'h8000_0000, 32'h0000_0001, lat);
        exp_res("divdvf", lat, 34, 32'h0000_8000, 6'b000001, 6'b010010, 1'b0);
        check("divdvf_z_s", zout_s, 32'h0000_8000);
        ack();

        run_op(3'b110, 32'h1111_2222, 32'h3333_4444, lat);
        exp_res("ill", lat, 1, 32'h0000_0000, 6'b000000, 6'b000000, 1'b1);
        ack();

        // Hold the result with out_ready low; an op offered meanwhile is dropped.
        run_op(OpMul, 32'h0003_0004, 32'h0001_0002, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                op       = OpAdd;
                z1       = 32'h0001_0001;
                z2       = 32'h0001_0001;
                in_valid = 1'b1;
            end
            check("hold_z", zout, 32'hFFFB_000A);
            check("hold_fr", flags_r, 6'b000010);
            check("hold_ov", out_valid, 1);
            check("hold_rdy", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ack();
        @(negedge clk);
        check("post_ov", out_valid, 0);
        check("post_rdy", in_ready, 1);
        check("post_z", zout, 32'hFFFB_000A);
        check("post_fr", flags_r, 6'b000010);
        repeat (3) begin
            @(negedge clk);
            check("no_queue", out_valid, 0);
        end

        // Reset in the middle of a divide.
        @(negedge clk);
        op       = OpDiv;
        z1       = 32'h0003_0004;
        z2       = 32'h0001_0002;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_ov", out_valid, 0);
        check("mid_rdy", in_ready, 1);
        check("mid_z", zout, 0);
        check("mid_f", {flags_r, flags_i}, 0);
        check("mid_ov_s", out_valid_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OpAdd, 32'h0010_0020, 32'h0001_0001, lat);
        exp_res("after_rst", lat, 1, 32'h0011_0021, 6'b000000, 6'b000000, 1'b0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
